dnn_accel_switch_debounce: RTL and testbench
============================================

// Module: dnn_accel_switch_debounce
// PURPOSE
//  - Conditions the raw board slide-switch bus before it reaches the switches PIO slave input port.
//  - Per bit: 2-flop synchronizer, then a saturating debounce counter.
//  - Drives a clean, glitch-free debounced_out bus, plus a one-cycle change strobe.
//  - Optional per-bit edge capture with an interrupt request.
// PARAMETERS
//  WIDTH            8       number of switch bits
//  DEBOUNCE_CYCLES  500000  consecutive cycles a new level must persist before acceptance (>=1; 10 ms @ 50 MHz)
//  CNT_W            20      debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//  clk            in   1      system clock
//  reset_n        in   1      asynchronous, active-low reset
//  sw_raw         in   WIDTH  asynchronous switch pins
//  debounced_out  out  WIDTH  debounced level; feeds the switches PIO in_port
//  changed        out  1      1-cycle pulse when any debounced_out bit updates
//  irq_ack        in   WIDTH  write-one-to-clear for edge_capture bits
//  edge_capture   out  WIDTH  sticky per-bit change flags
//  irq            out  1      |edge_capture
// BEHAVIOUR
//  - Reset (async assert, sync release): sync1, sync2, debounced_out, all counters, changed, edge_capture, irq = 0.
//  - Sync: on each rising edge, sync1 <= sw_raw and sync2 <= sync1.
//  - Per-bit FSM:
//    - STABLE: sync2[i] == debounced_out[i]; counter held at 0.
//    - PENDING: sync2[i] != debounced_out[i]; counter increments by 1 each cycle.
//  - Reverting to the stable level while PENDING: counter clears to 0 in that same cycle, no output change (glitch rejected).
//  - Acceptance: if the counter == DEBOUNCE_CYCLES-1 while still PENDING:
//    - debounced_out[i] <= sync2[i];
//    - counter <= 0;
//    - changed <= 1 on the next edge only.
//  - Latency: a sw_raw level held steady from edge k appears on debounced_out after edge k+1+DEBOUNCE_CYCLES.
//    - With DEBOUNCE_CYCLES=1, latency is 2 edges.
//  - Bits are fully independent. Multiple bits accepting in the same cycle produce a single changed pulse.
//  - Counter never wraps: it is cleared at acceptance, and CNT_W is sized to hold DEBOUNCE_CYCLES-1.
//  - Reset mid-count discards all pending counts. After release, a switch held high is re-accepted after the full latency.
//  - changed and debounced_out are registered outputs with no combinational path from sw_raw.
// CONFIGURATION
//  - SWITCH_DEBOUNCE_IRQ_EN defined:
//    - edge_capture[i] <= 1 on the cycle debounced_out[i] updates (either polarity).
//    - edge_capture[i] <= 0 when irq_ack[i]=1.
//    - A set and an ack on the same bit in the same cycle: set wins.
//    - irq is registered, = |edge_capture, and follows edge_capture by 0 cycles.
//  - SWITCH_DEBOUNCE_IRQ_EN undefined:
//    - edge_capture and irq are tied to 0.
//    - irq_ack is ignored.
//    - Ports are retained so the instantiation is identical in both builds.
// TESTING (WIDTH=8, DEBOUNCE_CYCLES=4, CNT_W=3)
//  1. Reset release with sw_raw=0x00 -> debounced_out=0x00, changed=0, irq=0 indefinitely.
//  2. sw_raw 0x00->0x01 at edge k, held -> debounced_out=0x01 after edge k+5; changed high exactly one cycle; no earlier change.
//  3. sw_raw bit1 pulses high for 3 cycles, then low -> debounced_out stays 0x00; changed never asserts.
//  4. sw_raw 0x00->0xA5 in one cycle, held -> all four bits update in the same cycle; a single changed pulse.
//  5. sw_raw=0x80 held 3 cycles, reset_n pulsed low, sw_raw still 0x80 -> debounced_out=0x00 during reset; 0x80 after the full 5-edge latency post-release.
//  6. (IRQ_EN) accept bit0, then irq_ack=0x01 -> edge_capture 0x01->0x00, irq falls.
//     Repeat with irq_ack coincident with a new bit0 acceptance -> edge_capture stays 0x01.
//     Without IRQ_EN: irq=0 throughout.

Source files
------------

// File: rtl/dnn_accel_switch_debounce.sv
// Switch conditioner: 2-flop synchronizer plus a saturating debounce counter per bit.
// Define SWITCH_DEBOUNCE_IRQ_EN to enable sticky edge capture and the irq output.
module dnn_accel_switch_debounce #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] debounced_out,
  output logic             changed,
  input  logic [WIDTH-1:0] irq_ack,
  output logic [WIDTH-1:0] edge_capture,
  output logic             irq
);

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } bit_state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] deb_q;
  logic [WIDTH-1:0] deb_d;
  logic [WIDTH-1:0] accept;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  bit_state_t       state [WIDTH];
  logic             changed_q;
  logic             changed_d;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] edge_d;
  logic             irq_q;
  logic             irq_d;

  // State register: synchronizer, debounced level, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1     <= '0;
      sync2     <= '0;
      deb_q     <= '0;
      changed_q <= 1'b0;
      edge_q    <= '0;
      irq_q     <= 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1     <= sw_raw;
      sync2     <= sync1;
      deb_q     <= deb_d;
      changed_q <= changed_d;
      edge_q    <= edge_d;
      irq_q     <= irq_d;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Next state: the per-bit state is implied by whether the synchronized input
  // disagrees with the accepted level, so it needs no storage of its own.
  always_comb begin
    deb_d  = deb_q;
    accept = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      state[i] = (sync2[i] == deb_q[i]) ? STABLE : PENDING;
      cnt_d[i] = '0;
      case (state[i])
        STABLE: cnt_d[i] = '0;
        PENDING: begin
          if (cnt_q[i] == CNT_LAST) begin
            accept[i] = 1'b1;
            deb_d[i]  = sync2[i];
            cnt_d[i]  = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: cnt_d[i] = '0;
      endcase
    end
  end

  // Outputs: all registered; irq is computed from the next edge_capture so both update together.
  always_comb begin
    changed_d = |accept;
`ifdef SWITCH_DEBOUNCE_IRQ_EN
    edge_d = (edge_q & ~irq_ack) | accept;
    irq_d  = |edge_d;
`else
    edge_d = '0;
    irq_d  = 1'b0;
`endif
  end

`ifndef SWITCH_DEBOUNCE_IRQ_EN
  logic unused_irq_ack;
  assign unused_irq_ack = ^irq_ack;
`endif

  assign debounced_out = deb_q;
  assign changed       = changed_q;
  assign edge_capture  = edge_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_dnn_accel_switch_debounce.sv
// Self-checking bench for dnn_accel_switch_debounce (WIDTH=8, DEBOUNCE_CYCLES=4, CNT_W=3).
// Works with or without SWITCH_DEBOUNCE_IRQ_EN defined.
module tb_dnn_accel_switch_debounce;

  localparam int W  = 8;
  localparam int DC = 4;

`ifdef SWITCH_DEBOUNCE_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] irq_ack = '0;
  logic [W-1:0] debounced_out;
  logic         changed;
  logic [W-1:0] edge_capture;
  logic         irq;

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  dnn_accel_switch_debounce #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(DC),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sw_raw(sw_raw),
    .debounced_out(debounced_out),
    .changed(changed),
    .irq_ack(irq_ack),
    .edge_capture(edge_capture),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: a bit is accepted when the last DC synchronized samples all disagree
  // with the current level. hist[j] holds sw_raw sampled j edges ago (0 during reset).
  logic [W-1:0] hist [0:DC+1];
  logic [W-1:0] m_deb = '0;
  logic         m_chg = 1'b0;
  logic [W-1:0] m_ec  = '0;
  logic         m_irq = 1'b0;

  function automatic logic [W-1:0] accept_mask();
    logic [W-1:0] a;
    a = '1;
    for (int j = 1; j <= DC; j++) begin
      a = a & (hist[j] ^ m_deb);
    end
    return a;
  endfunction

  function automatic logic [W-1:0] next_ec();
    return IRQ_ON ? ((m_ec & ~irq_ack) | accept_mask()) : '0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j <= DC + 1; j++) hist[j] <= '0;
      m_deb <= '0;
      m_chg <= 1'b0;
      m_ec  <= '0;
      m_irq <= 1'b0;
    end else begin
      for (int j = DC + 1; j > 0; j--) hist[j] <= hist[j-1];
      hist[0] <= sw_raw;
      m_deb   <= m_deb ^ accept_mask();
      m_chg   <= |accept_mask();
      m_ec    <= next_ec();
      m_irq   <= |next_ec();
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_debounced_out", debounced_out, m_deb);
      chk("model_changed", changed, m_chg);
      chk("model_edge_capture", edge_capture, m_ec);
      chk("model_irq", irq, m_irq);
    end
  end

  int pulses;

  initial begin
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    started = 1'b1;

    // 1: idle after reset
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("t1_deb", debounced_out, 8'h00);
      chk("t1_changed", changed, 1'b0);
      chk("t1_irq", irq, 1'b0);
    end

    // 3: 3-cycle glitch on bit1 is rejected
    sw_raw = 8'h02;
    repeat (3) @(negedge clk);
    sw_raw = 8'h00;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("t3_deb", debounced_out, 8'h00);
      chk("t3_changed", changed, 1'b0);
    end

    // 2: single bit accepted after 5 edges
    sw_raw = 8'h01;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("t2_deb_early", debounced_out, 8'h00);
      chk("t2_changed_early", changed, 1'b0);
    end
    @(negedge clk);
    chk("t2_deb", debounced_out, 8'h01);
    chk("t2_changed", changed, 1'b1);
    chk("t2_ec", edge_capture, IRQ_ON ? 8'h01 : 8'h00);
    @(negedge clk);
    chk("t2_changed_drop", changed, 1'b0);

    // 4: multi-bit acceptance gives one changed pulse
    sw_raw = 8'h00;
    repeat (8) @(negedge clk);
    chk("t4_pre", debounced_out, 8'h00);
    sw_raw = 8'hA5;
    pulses = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (changed) pulses++;
      if (c == 5) chk("t4_deb_early", debounced_out, 8'h00);
      if (c == 6) chk("t4_deb", debounced_out, 8'hA5);
    end
    chk("t4_pulses", pulses, 1);

    // 5: reset mid-count, then full latency after release
    sw_raw = 8'h80;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    @(negedge clk);
    chk("t5_deb_in_reset", debounced_out, 8'h00);
    chk("t5_irq_in_reset", irq, 1'b0);
    #2 reset_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("t5_deb_early", debounced_out, 8'h00);
    end
    @(negedge clk);
    chk("t5_deb", debounced_out, 8'h80);
    chk("t5_changed", changed, 1'b1);

    // 6: edge capture, ack, and set-wins-over-ack
    irq_ack = 8'hFF;
    @(negedge clk);
    irq_ack = 8'h00;
    chk("t6_cleared", edge_capture, 8'h00);
    sw_raw = 8'h81;
    repeat (6) @(negedge clk);
    chk("t6_deb", debounced_out, 8'h81);
    chk("t6_ec_set", edge_capture, IRQ_ON ? 8'h01 : 8'h00);
    chk("t6_irq_set", irq, IRQ_ON);
    irq_ack = 8'h01;
    @(negedge clk);
    irq_ack = 8'h00;
    chk("t6_ec_ack", edge_capture, 8'h00);
    chk("t6_irq_ack", irq, 1'b0);
    sw_raw = 8'h80;
    repeat (5) @(negedge clk);
    irq_ack = 8'h01;
    @(negedge clk);
    irq_ack = 8'h00;
    chk("t6_deb_fall", debounced_out, 8'h80);
    chk("t6_ec_setwins", edge_capture, IRQ_ON ? 8'h01 : 8'h00);
    chk("t6_irq_setwins", irq, IRQ_ON);
    repeat (3) @(negedge clk);

    started = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
